tm_step_sequencer: RTL and testbench
====================================

TM_STEP_SEQUENCER -- requirements
Module: tm_step_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable-level cycles needed before a button is accepted (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter MAX_SYMBOLS, default 16: maximum symbols loaded per computation; legal range 1..31.
REQ-003 clk100  input  1  single system clock, 100 MHz.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_next  input  1  raw "Next" push-button, asynchronous, active-high.
REQ-006 btn_done  input  1  raw "Done" push-button, asynchronous, active-high.
REQ-007 sw_data  input  4  raw slide-switch symbol value, asynchronous.
REQ-008 compute_done  input  1  Turing machine halt flag, level, clk100 domain.
REQ-009 tm_data  output  4  registered symbol presented to the Turing machine.
REQ-010 tm_next  output  1  one-cycle strobe: tm_data is a new tape symbol.
REQ-011 tm_done  output  1  one-cycle strobe: tape load complete, start computing.
REQ-012 symbol_count  output  5  number of symbols accepted since the last IDLE.
REQ-013 state_out  output  3  current FSM state encoding, for LEDs.
REQ-014 overflow  output  1  sticky flag: a Next press was refused at MAX_SYMBOLS.

Function
REQ-015 btn_next, btn_done and sw_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 A press SHALL be accepted on the cycle after its synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles, and SHALL yield exactly one event per press, with none on release.
REQ-017 The FSM states SHALL be IDLE=0, LOAD=1, RUN=2, HALT=3.
REQ-018 In IDLE or LOAD, a Next event with symbol_count < MAX_SYMBOLS SHALL cause the following, all on the same edge:
  - tm_data <= synchronized sw_data;
  - tm_next = 1 for one cycle;
  - symbol_count increments;
  - state <= LOAD.
REQ-019 A Next event at symbol_count == MAX_SYMBOLS SHALL be dropped: no tm_next, count held, overflow set to 1.
REQ-020 In IDLE or LOAD, a Done event SHALL assert tm_done for one cycle and move the FSM to RUN; zero loaded symbols is legal.
REQ-021 If Next and Done events occur in the same cycle, Done SHALL win and Next SHALL be discarded.
REQ-022 In RUN, all button events SHALL be ignored, and the FSM SHALL move to HALT on the first cycle compute_done is sampled high.
REQ-023 In HALT, a Next event SHALL return the FSM to IDLE and clear symbol_count and overflow without asserting tm_next; Done events SHALL be ignored.
REQ-024 tm_next and tm_done SHALL never be high in the same cycle.
REQ-025 tm_data SHALL hold its value between accepted Next events.

Reset
REQ-026 On reset_n low, all outputs SHALL be 0, the state SHALL be IDLE, and all debounce counters and synchronizers SHALL be cleared, taking effect immediately without a clock edge.
REQ-027 A button held through reset deassertion SHALL need a full DEBOUNCE_CYCLES stable interval after reset before it is accepted.
REQ-028 Reset during RUN SHALL abandon the computation with no tm_done or tm_next glitch.

Configuration
REQ-029 With TM_SEQ_DEBOUNCE_EN defined, debouncing SHALL follow REQ-016.
REQ-030 With TM_SEQ_DEBOUNCE_EN undefined, the debounce counters SHALL be removed and an event SHALL be the rising edge of the synchronized level, giving one-cycle latency after synchronization; DEBOUNCE_CYCLES is then unused.

Structure
REQ-031 Package tm_pkg SHALL hold:
  - the state enum tm_seq_state_t;
  - the symbol width constant TM_SYM_W = 4;
  - the count width constant TM_CNT_W = 5.
REQ-032 One sub-module, tm_btn_debounce, SHALL contain the synchronizer, the debouncer and the rising-edge pulse for one button, and SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES = 4, MAX_SYMBOLS = 3, TM_SEQ_DEBOUNCE_EN defined)
REQ-033 sw_data = 0xA; btn_next held for 10 cycles -> exactly one tm_next, tm_data = 0xA, symbol_count = 1, state = LOAD.
REQ-034 btn_next bounces 1-0-1-0 at 2-cycle intervals, then stays high for 6 cycles -> exactly one tm_next, occurring after the final stable interval.
REQ-035 4 Next presses with sw_data = 1, 2, 3, 4 -> three tm_next strobes with tm_data 1, 2, 3; symbol_count = 3; overflow = 1.
REQ-036 btn_next and btn_done asserted on the same cycle in LOAD -> tm_done only, state = RUN, symbol_count unchanged.
REQ-037 In RUN: a Next press gives no strobe; then compute_done = 1 -> state = HALT; then a Next press -> state = IDLE, symbol_count = 0, overflow = 0.
REQ-038 reset_n pulsed low mid-RUN -> all outputs 0 and state = IDLE immediately, with no strobe after release.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and widths for the Turing-machine tape step sequencer.
package tm_pkg;

    localparam int TM_SYM_W = 4;
    localparam int TM_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HALT = 3'd3
    } tm_seq_state_t;

endpackage

// File: rtl/tm_btn_debounce.sv
// One push-button: 2-flop synchronizer, optional debouncer (TM_SEQ_DEBOUNCE_EN)
// and a single-cycle press event.
module tm_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_event
);

    logic meta_q, meta_d;
    logic level_q, level_d;
    logic event_q, event_d;

`ifdef TM_SEQ_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q = cycles the synced level has already been high; saturating stops re-fire.
    always_comb begin
        meta_d  = btn_raw;
        level_d = meta_q;
        cnt_d   = '0;
        if (level_q) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
        event_d = level_q && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end
`else
    // Without debouncing the cycle count only guards against an illegal setting.
    localparam bit RANGE_OK = (DEBOUNCE_CYCLES >= 2);

    logic prev_q, prev_d;

    always_comb begin
        meta_d  = btn_raw;
        level_d = meta_q;
        prev_d  = level_q;
        event_d = RANGE_OK && level_q && !prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            event_q <= event_d;
        end
    end
`endif

    assign btn_event = event_q;

endmodule

// File: rtl/tm_step_sequencer.sv
// Loads switch symbols onto a Turing-machine tape via Next/Done buttons, then
// waits for the machine to halt. Debouncing is enabled by TM_SEQ_DEBOUNCE_EN.
module tm_step_sequencer
    import tm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_SYMBOLS     = 16
) (
    input  logic                clk100,
    input  logic                reset_n,
    input  logic                btn_next,
    input  logic                btn_done,
    input  logic [TM_SYM_W-1:0] sw_data,
    input  logic                compute_done,
    output logic [TM_SYM_W-1:0] tm_data,
    output logic                tm_next,
    output logic                tm_done,
    output logic [TM_CNT_W-1:0] symbol_count,
    output logic [2:0]          state_out,
    output logic                overflow
);

    localparam logic [TM_CNT_W-1:0] MAX_CNT = TM_CNT_W'(MAX_SYMBOLS);

    logic next_ev, done_ev;

    logic [TM_SYM_W-1:0] sw_meta_q, sw_meta_d;
    logic [TM_SYM_W-1:0] sw_sync_q, sw_sync_d;

    tm_seq_state_t       state_q, state_d;
    logic [TM_SYM_W-1:0] tm_data_q, tm_data_d;
    logic                tm_next_q, tm_next_d;
    logic                tm_done_q, tm_done_d;
    logic [TM_CNT_W-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;

    tm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
        .clk       (clk100),
        .rst_n     (reset_n),
        .btn_raw   (btn_next),
        .btn_event (next_ev)
    );

    tm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done_btn (
        .clk       (clk100),
        .rst_n     (reset_n),
        .btn_raw   (btn_done),
        .btn_event (done_ev)
    );

    always_comb begin
        sw_meta_d  = sw_data;
        sw_sync_d  = sw_meta_q;
        state_d    = state_q;
        tm_data_d  = tm_data_q;
        tm_next_d  = 1'b0;
        tm_done_d  = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE, LOAD: begin
                // Done has priority so a simultaneous Next is discarded.
                if (done_ev) begin
                    tm_done_d = 1'b1;
                    state_d   = RUN;
                end else if (next_ev) begin
                    if (count_q < MAX_CNT) begin
                        tm_data_d = sw_sync_q;
                        tm_next_d = 1'b1;
                        count_d   = count_q + 1'b1;
                        state_d   = LOAD;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (compute_done) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (next_ev) begin
                    state_d    = IDLE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            state_q    <= IDLE;
            tm_data_q  <= '0;
            tm_next_q  <= 1'b0;
            tm_done_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            state_q    <= state_d;
            tm_data_q  <= tm_data_d;
            tm_next_q  <= tm_next_d;
            tm_done_q  <= tm_done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign tm_data      = tm_data_q;
    assign tm_next      = tm_next_q;
    assign tm_done      = tm_done_q;
    assign symbol_count = count_q;
    assign state_out    = state_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_tm_step_sequencer.sv
// Directed bench for tm_step_sequencer with DEBOUNCE_CYCLES=4, MAX_SYMBOLS=3.
module tb_tm_step_sequencer;

    localparam int DEB_CYC = 4;
    localparam int MAX_SYM = 3;
`ifdef TM_SEQ_DEBOUNCE_EN
    localparam int LAT         = 7;
    localparam int BOUNCE_NEXT = 1;
`else
    localparam int LAT         = 4;
    localparam int BOUNCE_NEXT = 3;
`endif

    logic       clk100       = 1'b0;
    logic       reset_n      = 1'b1;
    logic       btn_next     = 1'b0;
    logic       btn_done     = 1'b0;
    logic [3:0] sw_data      = 4'h0;
    logic       compute_done = 1'b0;
    logic [3:0] tm_data;
    logic       tm_next;
    logic       tm_done;
    logic [4:0] symbol_count;
    logic [2:0] state_out;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nexts = 0;
    int dones = 0;
    int both = 0;
    int last_next_cyc = 0;
    int mark_cyc = 0;
    int n0, d0;

    tm_step_sequencer #(
        .DEBOUNCE_CYCLES (DEB_CYC),
        .MAX_SYMBOLS     (MAX_SYM)
    ) dut (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .btn_next     (btn_next),
        .btn_done     (btn_done),
        .sw_data      (sw_data),
        .compute_done (compute_done),
        .tm_data      (tm_data),
        .tm_next      (tm_next),
        .tm_done      (tm_done),
        .symbol_count (symbol_count),
        .state_out    (state_out),
        .overflow     (overflow)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    always @(negedge clk100) begin
        if (tm_next) begin
            nexts = nexts + 1;
            last_next_cyc = cyc;
        end
        if (tm_done) dones = dones + 1;
        if (tm_next && tm_done) both = both + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_data"},     32'(tm_data),      32'h0);
        check({pfx, "_next"},     32'(tm_next),      32'h0);
        check({pfx, "_done"},     32'(tm_done),      32'h0);
        check({pfx, "_count"},    32'(symbol_count), 32'h0);
        check({pfx, "_state"},    32'(state_out),    32'h0);
        check({pfx, "_overflow"}, 32'(overflow),     32'h0);
    endtask

    task automatic press(input logic nx, input logic dn, input int hold);
        @(negedge clk100);
        btn_next = nx;
        btn_done = dn;
        mark_cyc = cyc;
        repeat (hold) @(negedge clk100);
        btn_next = 1'b0;
        btn_done = 1'b0;
        repeat (12) @(negedge clk100);
    endtask

    task automatic do_reset();
        @(negedge clk100);
        reset_n = 1'b0;
        repeat (2) @(negedge clk100);
        reset_n = 1'b1;
        repeat (2) @(negedge clk100);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(negedge clk100);
        reset_n = 1'b1;
        repeat (2) @(negedge clk100);

        // Single long press loads one symbol
        sw_data = 4'hA;
        n0 = nexts;
        press(1'b1, 1'b0, 10);
        check("t1_nexts",   32'(nexts - n0),               32'd1);
        check("t1_latency", 32'(last_next_cyc - mark_cyc), 32'(LAT));
        check("t1_data",    32'(tm_data),                  32'hA);
        check("t1_count",   32'(symbol_count),             32'd1);
        check("t1_state",   32'(state_out),                32'd1);

        // Bouncing contact, then a stable interval
        do_reset();
        sw_data = 4'h7;
        n0 = nexts;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk100); btn_next = 1'b1;
            @(negedge clk100);
            @(negedge clk100); btn_next = 1'b0;
            @(negedge clk100);
        end
        @(negedge clk100);
        btn_next = 1'b1;
        mark_cyc = cyc;
        repeat (6) @(negedge clk100);
        btn_next = 1'b0;
        repeat (12) @(negedge clk100);
        check("t2_nexts",   32'(nexts - n0),               32'(BOUNCE_NEXT));
        check("t2_latency", 32'(last_next_cyc - mark_cyc), 32'(LAT));
        check("t2_count",   32'(symbol_count),             32'(BOUNCE_NEXT));
        check("t2_data",    32'(tm_data),                  32'h7);

        // Fill to MAX_SYMBOLS, then one refused press
        do_reset();
        n0 = nexts;
        for (int i = 1; i <= 4; i++) begin
            sw_data = 4'(i);
            press(1'b1, 1'b0, 10);
            check($sformatf("t3_data_%0d", i),  32'(tm_data),     32'((i < 3) ? i : 3));
            check($sformatf("t3_nexts_%0d", i), 32'(nexts - n0),  32'((i < 3) ? i : 3));
        end
        check("t3_count",    32'(symbol_count), 32'd3);
        check("t3_overflow", 32'(overflow),     32'd1);
        check("t3_state",    32'(state_out),    32'd1);

        // Next and Done together: Done wins
        n0 = nexts;
        d0 = dones;
        press(1'b1, 1'b1, 10);
        check("t4_dones", 32'(dones - d0),    32'd1);
        check("t4_nexts", 32'(nexts - n0),    32'd0);
        check("t4_state", 32'(state_out),     32'd2);
        check("t4_count", 32'(symbol_count),  32'd3);

        // RUN ignores buttons; halt; HALT ignores Done, Next returns to IDLE
        n0 = nexts;
        d0 = dones;
        sw_data = 4'hE;
        press(1'b1, 1'b0, 10);
        press(1'b0, 1'b1, 10);
        check("t5_run_nexts", 32'(nexts - n0), 32'd0);
        check("t5_run_dones", 32'(dones - d0), 32'd0);
        check("t5_run_state", 32'(state_out),  32'd2);
        @(negedge clk100); compute_done = 1'b1;
        @(negedge clk100); compute_done = 1'b0;
        check("t5_halt_state", 32'(state_out), 32'd3);
        press(1'b0, 1'b1, 10);
        check("t5_halt_done_state", 32'(state_out), 32'd3);
        check("t5_halt_dones",      32'(dones - d0), 32'd0);
        press(1'b1, 1'b0, 10);
        check("t5_idle_state",    32'(state_out),    32'd0);
        check("t5_idle_count",    32'(symbol_count), 32'd0);
        check("t5_idle_overflow", 32'(overflow),     32'd0);
        check("t5_idle_nexts",    32'(nexts - n0),   32'd0);
        check("t5_data_held",     32'(tm_data),      32'h3);

        // Both buttons below MAX_SYMBOLS: count must not move
        do_reset();
        sw_data = 4'h5;
        press(1'b1, 1'b0, 10);
        n0 = nexts;
        d0 = dones;
        press(1'b1, 1'b1, 10);
        check("t6_dones", 32'(dones - d0),   32'd1);
        check("t6_nexts", 32'(nexts - n0),   32'd0);
        check("t6_count", 32'(symbol_count), 32'd1);
        check("t6_state", 32'(state_out),    32'd2);

        // Asynchronous reset in RUN, between clock edges
        n0 = nexts;
        d0 = dones;
        @(negedge clk100);
        #2 reset_n = 1'b0;
        #1 check_zero("t7_rst");
        repeat (2) @(negedge clk100);
        reset_n = 1'b1;
        repeat (20) @(negedge clk100);
        check("t7_nexts", 32'(nexts - n0), 32'd0);
        check("t7_dones", 32'(dones - d0), 32'd0);
        check("t7_state", 32'(state_out),  32'd0);

        // Done with zero symbols loaded
        press(1'b0, 1'b1, 10);
        check("t8_dones", 32'(dones - d0),   32'd1);
        check("t8_state", 32'(state_out),    32'd2);
        check("t8_count", 32'(symbol_count), 32'd0);

        // Button held through reset needs a full interval after release
        sw_data = 4'h6;
        n0 = nexts;
        @(negedge clk100);
        btn_next = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk100);
        reset_n  = 1'b1;
        mark_cyc = cyc;
        repeat (12) @(negedge clk100);
        btn_next = 1'b0;
        repeat (12) @(negedge clk100);
        check("t9_nexts",   32'(nexts - n0),               32'd1);
        check("t9_latency", 32'(last_next_cyc - mark_cyc), 32'(LAT));
        check("t9_data",    32'(tm_data),                  32'h6);
        check("t9_count",   32'(symbol_count),             32'd1);
        check("t9_state",   32'(state_out),                32'd1);

        check("strobe_overlap", 32'(both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
